// File: rtl/scan_row_drive.sv
// scan_row_drive: normal-display row scan driver.
// Per row: wait for a line, shift the columns out (read / shift alternating),
// serialise the 10-bit row address LSB first, then fire g1, g2 and ren/woe.
// Every output is a flop; each transition loads the values for the next cycle.
module scan_row_drive #(
   parameter int ROW_NUM = 1024,
   parameter int COL_CLK = 64,
   parameter int DW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_op,
   input  logic          frame_start,
   input  logic          line_rdy,
   output logic          line_req,
   output logic          col_rd,
   input  logic [DW-1:0] col_data_in,
   output logic [DW-1:0] col_data,
   output logic          col_start,
   output logic          col_shift,
   output logic          lrn,
   output logic          g1,
   output logic          g2,
   output logic          ren,
   output logic          woe,
   output logic          row_data,
   output logic [9:0]    row_idx,
   output logic          busy,
   output logic          frame_done,
   output logic          frame_ovr
);

   // Step counter is shared by SHIFT (up to 2*255-1), ADDR and STROBE.
   localparam int             CW         = 10;
   localparam logic [CW-1:0]  SHIFT_LAST = CW'(2 * COL_CLK - 1);
   localparam logic [CW-1:0]  ADDR_LAST  = CW'(9);
   localparam logic [CW-1:0]  STB_LAST   = CW'(4);
   localparam logic [9:0]     ROW_LAST   = 10'(ROW_NUM - 1);

   // The row-advance decision is taken on the edge that leaves the last
   // STROBE step, so the next row's line_req (or frame_done) appears in the
   // cycle right after the strobes, giving a 2*COL_CLK+16 cycle row period.
   typedef enum logic [2:0] {
      IDLE,
      WAIT_LINE,
      SHIFT,
      ADDR,
      STROBE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Scan FSM: state, step counter and all registered panel outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         line_req   <= 1'b0;
         col_rd     <= 1'b0;
         col_data   <= '0;
         col_start  <= 1'b0;
         col_shift  <= 1'b0;
         lrn        <= 1'b1;
         g1         <= 1'b0;
         g2         <= 1'b0;
         ren        <= 1'b0;
         woe        <= 1'b0;
         row_data   <= 1'b0;
         row_idx    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_ovr  <= 1'b0;
      end else begin
         // Strobes and pulses idle unless the next cycle's step asks for them.
         line_req   <= 1'b0;
         col_rd     <= 1'b0;
         col_start  <= 1'b0;
         col_shift  <= 1'b0;
         lrn        <= 1'b1;
         g1         <= 1'b0;
         g2         <= 1'b0;
         ren        <= 1'b0;
         woe        <= 1'b0;
         row_data   <= 1'b0;
         frame_done <= 1'b0;
         frame_ovr  <= 1'b0;

         // The FWFT word is consumed in the cycle col_rd is high; holding it
         // here keeps col_data steady through the following shift-high cycle.
         if (col_rd)
            col_data <= col_data_in;

         if (busy && clr_op) begin
            // Clear sequencer took the pins back: drop the frame silently.
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            row_idx  <= '0;
            col_data <= '0;
         end else begin
            if (busy && frame_start)
               frame_ovr <= 1'b1;

            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (frame_start && !clr_op) begin
                     state    <= WAIT_LINE;
                     line_req <= 1'b1;
                     busy     <= 1'b1;
                     row_idx  <= '0;
                  end
               end

               WAIT_LINE: begin
                  // line_req is high for the whole of this state, so the
                  // accept edge is simply line_rdy sampled here.
                  if (line_rdy) begin
                     state     <= SHIFT;
                     cnt       <= '0;
                     col_rd    <= 1'b1;
                     col_start <= 1'b1;
                  end else begin
                     line_req <= 1'b1;
                  end
               end

               SHIFT: begin
                  if (cnt == SHIFT_LAST) begin
                     state    <= ADDR;
                     cnt      <= '0;
                     lrn      <= 1'b0;
                     row_data <= row_idx[0];
                  end else begin
                     cnt <= cnt + CW'(1);
                     // Even steps read a word, odd steps clock it into the panel.
                     if (cnt[0])
                        col_rd <= 1'b1;
                     else
                        col_shift <= 1'b1;
                  end
               end

               ADDR: begin
                  lrn <= 1'b0;
                  if (cnt == ADDR_LAST) begin
                     state <= STROBE;
                     cnt   <= '0;
                     g1    <= 1'b1;
                  end else begin
                     cnt      <= cnt + CW'(1);
                     row_data <= row_idx[cnt[3:0] + 4'd1];
                  end
               end

               STROBE: begin
                  if (cnt == STB_LAST) begin
                     cnt <= '0;
                     if (row_idx == ROW_LAST) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        row_idx    <= '0;
                     end else begin
                        state    <= WAIT_LINE;
                        line_req <= 1'b1;
                        row_idx  <= row_idx + 10'd1;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                     lrn <= 1'b0;
                     if (cnt == '0) begin
                        g2 <= 1'b1;
                     end else begin
                        ren <= 1'b1;
                        woe <= 1'b1;
                     end
                  end
               end

               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scan_row_drive.sv
// Self-checking bench for scan_row_drive (ROW_NUM=4, COL_CLK=4).
// A timeline model (cycle offset from the accept edge) predicts every output
// each cycle; directed tables and sequences cover the listed corner cases.
module tb_scan_row_drive;

   localparam int ROWS = 4;
   localparam int C    = 4;
   localparam int DW   = 8;

   logic          clk = 1'b0;
   logic          rst, clr_op, frame_start, line_rdy;
   logic [DW-1:0] col_data_in;
   logic          line_req, col_rd, col_start, col_shift, lrn, g1, g2, ren, woe, row_data;
   logic [DW-1:0] col_data;
   logic [9:0]    row_idx;
   logic          busy, frame_done, frame_ovr;

   scan_row_drive #(.ROW_NUM(ROWS), .COL_CLK(C), .DW(DW)) dut (
      .clk(clk), .rst(rst), .clr_op(clr_op), .frame_start(frame_start),
      .line_rdy(line_rdy), .line_req(line_req), .col_rd(col_rd),
      .col_data_in(col_data_in), .col_data(col_data), .col_start(col_start),
      .col_shift(col_shift), .lrn(lrn), .g1(g1), .g2(g2), .ren(ren), .woe(woe),
      .row_data(row_data), .row_idx(row_idx), .busy(busy),
      .frame_done(frame_done), .frame_ovr(frame_ovr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          line_req, col_rd;
      logic [DW-1:0] col_data;
      logic          col_start, col_shift, lrn, g1, g2, ren, woe, row_data;
      logic [9:0]    row_idx;
      logic          busy, frame_done, frame_ovr;
   } ov_t;

   int checks = 0;
   int failures = 0;

   // Reference model: idle / waiting for a line / t cycles after accept edge.
   int            m_busy, m_wait, m_t, m_row, m_done, m_ovr;
   logic [DW-1:0] m_cd;

   // Stimulus bookkeeping and monitors.
   int   head, cyc_n, lr_cnt, ovr_cnt, done_cnt, done_cyc, first_cs;
   bit   pat_mode;
   logic [DW-1:0] shq[$];
   logic          rdq[$];
   ov_t  rv;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic ov_t dut_vec();
      ov_t o;
      o.line_req = line_req;  o.col_rd = col_rd;   o.col_data = col_data;
      o.col_start = col_start; o.col_shift = col_shift; o.lrn = lrn;
      o.g1 = g1; o.g2 = g2; o.ren = ren; o.woe = woe; o.row_data = row_data;
      o.row_idx = row_idx; o.busy = busy; o.frame_done = frame_done;
      o.frame_ovr = frame_ovr;
      return o;
   endfunction

   function automatic ov_t model_out();
      ov_t o;
      bit  in_sh, in_addr;
      o = '0;
      in_sh   = (m_t >= 1) && (m_t <= 2*C);
      in_addr = (m_t >= 2*C+1) && (m_t <= 2*C+10);
      o.line_req  = (m_busy != 0) && (m_wait != 0);
      o.col_start = (m_t == 1);
      o.col_rd    = in_sh && (m_t % 2 == 1);
      o.col_shift = in_sh && (m_t % 2 == 0);
      o.lrn       = !((m_t >= 2*C+1) && (m_t <= 2*C+15));
      o.row_data  = in_addr ? ((m_row >> (m_t - 2*C - 1)) & 1) != 0 : 1'b0;
      o.g1        = (m_t == 2*C+11);
      o.g2        = (m_t == 2*C+12);
      o.ren       = (m_t >= 2*C+13) && (m_t <= 2*C+15);
      o.woe       = o.ren;
      o.row_idx   = 10'(m_row);
      o.busy      = m_busy != 0;
      o.frame_done = m_done != 0;
      o.frame_ovr  = m_ovr != 0;
      o.col_data  = m_cd;
      return o;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_wait = 0; m_t = 0; m_row = 0; m_done = 0; m_ovr = 0; m_cd = '0;
   endtask

   // Advance the model across one clock edge using the inputs it sampled.
   task automatic model_step();
      ov_t cur;
      if (rst) begin
         model_reset();
      end else begin
         cur = model_out();
         m_done = 0; m_ovr = 0;
         if (m_busy != 0 && clr_op) begin
            model_reset();
         end else begin
            if (cur.col_rd) m_cd = col_data_in;
            if (m_busy != 0 && frame_start) m_ovr = 1;
            if (m_busy == 0) begin
               if (frame_start && !clr_op) begin m_busy = 1; m_wait = 1; m_row = 0; end
            end else if (m_wait != 0) begin
               if (line_rdy) begin m_wait = 0; m_t = 1; end
            end else if (m_t == 2*C+15) begin
               m_t = 0;
               if (m_row == ROWS-1) begin m_busy = 0; m_row = 0; m_done = 1; end
               else begin m_row++; m_wait = 1; end
            end else begin
               m_t++;
            end
         end
      end
   endtask

   function automatic logic [DW-1:0] pat(input int h);
      return DW'(8'h11 * ((h % 4) + 1));
   endfunction

   // One clock: edge, model step, compare at +1, then monitors.
   task automatic cyc();
      ov_t e;
      if (pat_mode) col_data_in = pat(head);
      e = model_out();
      @(posedge clk);
      model_step();
      if (e.col_rd) head++;
      #1;
      chk("model", 64'(dut_vec()), 64'(model_out()));
      cyc_n++;
      if (col_shift && row_idx == 10'd0) shq.push_back(col_data);
      if (!lrn && !g1 && !g2 && !ren && row_idx == 10'd2) rdq.push_back(row_data);
      if (line_req && row_idx == 10'd1) lr_cnt++;
      if (frame_ovr) ovr_cnt++;
      if (frame_done) begin done_cnt++; done_cyc = cyc_n; end
      if (col_start && first_cs < 0) first_cs = cyc_n;
   endtask

   task automatic clear_mon();
      shq.delete(); rdq.delete();
      lr_cnt = 0; ovr_cnt = 0; done_cnt = 0; done_cyc = 0; first_cs = -1;
   endtask

   typedef struct {
      logic clr, fs, rdy;
      logic lr, bsy, cs, cr;
   } vec_t;

   initial begin
      vec_t        tbl[8];
      logic [9:0]  bits;
      bit          sent;
      int          stall;

      tbl[0] = '{1, 1, 1, 0, 0, 0, 0};  // frame_start ignored under clr_op
      tbl[1] = '{1, 0, 1, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 0, 0, 0, 0, 0};
      tbl[3] = '{0, 1, 0, 1, 1, 0, 0};  // F: line_req from F+1
      tbl[4] = '{0, 0, 0, 1, 1, 0, 0};
      tbl[5] = '{0, 0, 1, 0, 1, 1, 1};  // accept edge: col_start + col_rd
      tbl[6] = '{0, 0, 1, 0, 1, 0, 0};
      tbl[7] = '{0, 0, 1, 0, 1, 0, 1};

      rv = '0; rv.lrn = 1'b1;
      rst = 1'b1; clr_op = 1'b0; frame_start = 1'b0; line_rdy = 1'b0;
      col_data_in = '0; head = 0; cyc_n = 0; pat_mode = 1'b1;
      model_reset(); clear_mon();
      repeat (3) cyc();
      rst = 1'b0;
      chk("reset_state", 64'(dut_vec()), 64'(rv));

      // Frame 1: start-up table, then a free-running frame with line_rdy high.
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         clr_op = tbl[i].clr; frame_start = tbl[i].fs; line_rdy = tbl[i].rdy;
         cyc();
         chk($sformatf("tbl%0d_line_req", i), 64'(line_req), 64'(tbl[i].lr));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
         chk($sformatf("tbl%0d_col_start", i), 64'(col_start), 64'(tbl[i].cs));
         chk($sformatf("tbl%0d_col_rd", i), 64'(col_rd), 64'(tbl[i].cr));
      end
      frame_start = 1'b0; line_rdy = 1'b1;
      for (int i = 0; i < 300 && done_cnt == 0; i++) cyc();
      chk("f1_done", 64'(done_cnt), 64'd1);
      chk("f1_shift_cnt", 64'(shq.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("f1_col_data%0d", i), 64'(shq.size() > i ? shq[i] : 8'hxx), 64'(pat(i)));
      chk("f1_rowdata_len", 64'(rdq.size()), 64'd10);
      bits = '0;
      for (int i = 0; i < 10 && i < rdq.size(); i++) bits[i] = rdq[i];
      chk("f1_rowdata_row2", 64'(bits), 64'b0000000010);
      chk("f1_frame_len", 64'(done_cyc - first_cs), 64'd95);
      chk("f1_idle", 64'(busy), 64'd0);

      // Frame 2: stall row 1 by holding line_rdy low for 7 cycles.
      clear_mon(); stall = 0;
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
         if (row_idx == 10'd1 && line_req && stall < 7) begin line_rdy = 1'b0; stall++; end
         else line_rdy = 1'b1;
         cyc();
      end
      line_rdy = 1'b1;
      chk("stall_line_req_len", 64'(lr_cnt), 64'd8);
      chk("stall_done", 64'(done_cnt), 64'd1);

      // Frame 3: frame_start during row 2 must only pulse frame_ovr.
      clear_mon(); sent = 1'b0;
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
         frame_start = (row_idx == 10'd2 && col_shift && !sent);
         if (frame_start) sent = 1'b1;
         cyc();
      end
      frame_start = 1'b0;
      chk("ovr_count", 64'(ovr_cnt), 64'd1);
      chk("ovr_done", 64'(done_cnt), 64'd1);

      // Abort by clr_op during SHIFT.
      clear_mon();
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      for (int i = 0; i < 100 && !col_shift; i++) cyc();
      chk("abort_reach_shift", 64'(col_shift), 64'd1);
      clr_op = 1'b1; cyc();
      chk("clr_abort_state", 64'(dut_vec()), 64'(rv));
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      repeat (3) cyc();
      chk("clr_abort_busy", 64'(busy), 64'd0);
      chk("clr_abort_no_done", 64'(done_cnt), 64'd0);
      clr_op = 1'b0; cyc();

      // Asynchronous reset during STROBE.
      clear_mon();
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      for (int i = 0; i < 100 && !g2; i++) cyc();
      chk("rst_reach_strobe", 64'(g2), 64'd1);
      rst = 1'b1; #1;
      chk("rst_async_state", 64'(dut_vec()), 64'(rv));
      cyc();
      rst = 1'b0;
      repeat (2) cyc();
      chk("rst_idle_state", 64'(dut_vec()), 64'(rv));
      chk("rst_no_done", 64'(done_cnt), 64'd0);

      // Randomised traffic against the model.
      pat_mode = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         col_data_in = DW'($urandom);
         line_rdy    = ($urandom_range(0, 99) < 70);
         frame_start = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 199) < 2) clr_op = ~clr_op;
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
